uart_sample_sequencer: RTL and testbench
========================================

UART_SAMPLE_SEQUENCER -- requirements
Module: uart_sample_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1_000_000: max cycles waited for the high byte after the low byte (10 ms at 100 MHz).
REQ-002 SHALL have parameter TO_BITS, default 20: width of the timeout counter.
REQ-003 SHALL have port clk_100MHz  in  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_empty  in  1  Rx FIFO empty flag.
REQ-006 SHALL have port rx_data  in  8  Rx FIFO head word, valid whenever rx_empty=0.
REQ-007 SHALL have port rx_rd  out  1  Rx FIFO pop strobe, one cycle per byte.
REQ-008 SHALL have port tx_full  in  1  Tx FIFO full flag.
REQ-009 SHALL have port tx_wr  out  1  Tx FIFO push strobe.
REQ-010 SHALL have port tx_data  out  8  byte pushed with tx_wr.
REQ-011 SHALL have port smp_valid  out  1  sample offered to filter.
REQ-012 SHALL have port smp_data  out  16  sample value {hi,lo}.
REQ-013 SHALL have port smp_ready  in  1  filter accepts sample.
REQ-014 SHALL have port res_valid  in  1  filter result available.
REQ-015 SHALL have port res_data  in  16  filter result.
REQ-016 SHALL have port res_ready  out  1  sequencer accepts result.
REQ-017 SHALL have port busy  out  1  high in every state except RD_LO.
REQ-018 SHALL have port frame_cnt  out  16  completed frames, wraps 0xFFFF->0.
REQ-019 SHALL have port err_cnt  out  8  timed-out partial frames, saturates at 0xFF.

Function
REQ-020 SHALL implement FSM states RD_LO, RD_HI, SEND, WAIT_RES, WR_LO, WR_HI.
REQ-021 RD_LO: rx_rd=~rx_empty, combinational; on pop, latch rx_data into the low byte, clear the timer, go to RD_HI.
REQ-022 RD_HI: on ~rx_empty, pop and latch the high byte, go to SEND; otherwise increment the timer.
REQ-023 RD_HI: timer==TIMEOUT_CYC-1 with rx_empty=1 SHALL discard the low byte, increment err_cnt (saturating), and return to RD_LO.
REQ-024 A byte that arrives in the same cycle as the timeout SHALL be accepted, with no error.
REQ-025 SEND: smp_valid=1 with smp_data stable; on smp_ready=1 go to WAIT_RES; smp_valid SHALL NOT drop before the handshake.
REQ-026 WAIT_RES: res_ready=1; on res_valid, latch res_data and go to WR_LO; res_valid outside WAIT_RES SHALL be ignored.
REQ-027 WR_LO: tx_wr=~tx_full, tx_data=result[7:0]; on push go to WR_HI.
REQ-028 WR_HI: tx_wr=~tx_full, tx_data=result[15:8]; on push increment frame_cnt and go to RD_LO.
REQ-029 tx_full=1 SHALL stall in place with no data loss; rx_empty in RD_LO SHALL idle indefinitely.
REQ-030 Minimum latency from the first rx_rd to the second tx_wr SHALL be 5 cycles (filter ready and results immediate).
REQ-031 rx_rd and tx_wr SHALL never be asserted in the same cycle.

Reset
REQ-032 On reset assertion, immediately and asynchronously: state=RD_LO; sample, result, timer, frame_cnt and err_cnt=0; smp_valid, res_ready, tx_wr, busy=0.
REQ-033 rx_rd SHALL follow REQ-021 once reset deasserts; reset mid-frame SHALL drop all partial data without emitting bytes.

Structure
REQ-034 uart_pkg SHALL hold the state encoding, DBITS=8, and the sample width 16.
REQ-035 No sub-module is required; the timeout counter stays inline.

Verification
REQ-036 Bench SHALL push Rx bytes 0x34, 0x12; filter echoes after 0 cycles -> smp_data=0x1234, Tx bytes 0x34 then 0x12, frame_cnt=1.
REQ-037 Bench SHALL hold tx_full=1 for 50 cycles in WR_LO -> tx_wr=0 throughout; bytes emitted in order after release.
REQ-038 Bench SHALL use TIMEOUT_CYC=8 and push only 0xAA -> return to RD_LO after 8 cycles, err_cnt=1, no smp_valid; a later 0x01, 0x02 pair yields 0x0201.
REQ-039 Bench SHALL hold smp_ready=0 for 20 cycles -> smp_valid held high, smp_data constant.
REQ-040 Bench SHALL assert reset in WAIT_RES -> all outputs zero next sample; no Tx push before a new frame.
REQ-041 Bench SHALL run 65536 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART sample sequencer: state encoding, data widths
// and the saturating error-count helper.
package uart_pkg;

    localparam int DBITS = 8;
    localparam int SMP_W = 16;

    localparam logic [2:0] RD_LO    = 3'd0;
    localparam logic [2:0] RD_HI    = 3'd1;
    localparam logic [2:0] SEND     = 3'd2;
    localparam logic [2:0] WAIT_RES = 3'd3;
    localparam logic [2:0] WR_LO    = 3'd4;
    localparam logic [2:0] WR_HI    = 3'd5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_sample_sequencer.sv
// Assembles two Rx bytes into a 16-bit sample, hands it to a filter, and writes
// the filter result back to the Tx FIFO low byte first. Stalled partial frames time out.
module uart_sample_sequencer
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int TO_BITS     = 20
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [DBITS-1:0]  rx_data,
    output logic              rx_rd,
    input  logic              tx_full,
    output logic              tx_wr,
    output logic [DBITS-1:0]  tx_data,
    output logic              smp_valid,
    output logic [SMP_W-1:0]  smp_data,
    input  logic              smp_ready,
    input  logic              res_valid,
    input  logic [SMP_W-1:0]  res_data,
    output logic              res_ready,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        err_cnt
);

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYC - 1);

    logic [2:0]         state;
    logic [SMP_W-1:0]   sample_q;
    logic [SMP_W-1:0]   result_q;
    logic [TO_BITS-1:0] timer_q;

    // Handshake strobes are pure decodes of the state so they drop with reset immediately.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        rx_rd   = 1'b0;
        tx_wr   = 1'b0;
        tx_data = '0;
        if (!reset && (state == RD_LO || state == RD_HI))
            rx_rd = ~rx_empty;
        if (state == WR_LO) begin
            tx_wr   = ~tx_full;
            tx_data = result_q[DBITS-1:0];
        end else if (state == WR_HI) begin
            tx_wr   = ~tx_full;
            tx_data = result_q[SMP_W-1:DBITS];
        end
    end

    assign smp_valid = (state == SEND);
    assign res_ready = (state == WAIT_RES);
    assign busy      = (state != RD_LO);
    assign smp_data  = sample_q;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state     <= RD_LO;
            sample_q  <= '0;
            result_q  <= '0;
            timer_q   <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                RD_LO: begin
                    if (!rx_empty) begin
                        sample_q[DBITS-1:0] <= rx_data;
                        timer_q             <= '0;
                        state               <= RD_HI;
                    end
                end
                RD_HI: begin
                    // A byte arriving on the final timeout cycle still wins.
                    if (!rx_empty) begin
                        sample_q[SMP_W-1:DBITS] <= rx_data;
                        state                   <= SEND;
                    end else if (timer_q == TO_LAST) begin
                        sample_q <= '0;
                        err_cnt  <= sat_inc8(err_cnt);
                        state    <= RD_LO;
                    end else begin
                        timer_q <= timer_q + TO_BITS'(1);
                    end
                end
                SEND: begin
                    if (smp_ready)
                        state <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        result_q <= res_data;
                        state    <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (!tx_full)
                        state <= WR_HI;
                end
                WR_HI: begin
                    if (!tx_full) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= RD_LO;
                    end
                end
                default: state <= RD_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sample_sequencer.sv
// Scoreboard bench for uart_sample_sequencer: Rx FIFO model, echoing filter model,
// Tx/sample monitors popping expected queues, and one task per scenario.
module tb_uart_sample_sequencer;

    localparam int TIMEOUT_CYC = 8;
    localparam int TO_BITS     = 4;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b1;
    logic        rx_empty   = 1'b1;
    logic [7:0]  rx_data    = 8'h00;
    logic        rx_rd;
    logic        tx_full    = 1'b0;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic        smp_ready  = 1'b1;
    logic        res_valid  = 1'b0;
    logic [15:0] res_data   = 16'h0000;
    logic        res_ready;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_sample_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_BITS(TO_BITS)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  rx_q[$];
    logic [15:0] smp_q[$];
    logic [7:0]  tx_q[$];
    logic [15:0] exp_frames = 16'h0000;
    logic [7:0]  exp_err    = 8'h00;

    always @(posedge clk_100MHz) cyc <= cyc + 1;

    // Rx FIFO model: pop decided at the negedge, applied just after the posedge.
    bit do_pop;
    always begin
        @(negedge clk_100MHz);
        do_pop = rx_rd;
        @(posedge clk_100MHz);
        #2;
        if (do_pop && rx_q.size() > 0) void'(rx_q.pop_front());
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    end

    // Filter model: echoes each accepted sample, optionally stalled by res_stall.
    bit          hs_smp, hs_res, res_armed, res_stall;
    logic [15:0] cap, res_cap;
    initial begin res_armed = 1'b0; res_stall = 1'b0; end
    always begin
        @(negedge clk_100MHz);
        hs_smp = smp_valid && smp_ready;
        hs_res = res_valid && res_ready;
        cap    = smp_data;
        @(posedge clk_100MHz);
        #2;
        if (reset) begin
            res_valid = 1'b0;
            res_armed = 1'b0;
        end else begin
            if (hs_res) res_valid = 1'b0;
            if (hs_smp) begin res_armed = 1'b1; res_cap = cap; end
            if (res_armed && !res_stall) begin
                res_valid = 1'b1;
                res_data  = res_cap;
                res_armed = 1'b0;
            end
        end
    end

    // Output monitors: sample handshakes and Tx pushes are checked against the scoreboard.
    always @(negedge clk_100MHz) begin
        if (!reset) begin
            checks++;
            if (rx_rd && tx_wr) begin
                errors++;
                $display("FAIL rx_tx_overlap: rx_rd=%b tx_wr=%b required not both 1 (cycle %0d)", rx_rd, tx_wr, cyc);
            end
            if (smp_valid && smp_ready) begin
                checks++;
                if (smp_q.size() == 0) begin
                    errors++;
                    $display("FAIL smp_unexpected: got %h, required no sample", smp_data);
                end else begin
                    logic [15:0] e;
                    e = smp_q.pop_front();
                    if (smp_data !== e) begin
                        errors++;
                        $display("FAIL smp_data: got %h required %h", smp_data, e);
                    end
                end
            end
            if (tx_wr) begin
                checks++;
                if (tx_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %h, required no push", tx_data);
                end else begin
                    logic [7:0] e;
                    e = tx_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_data: got %h required %h", tx_data, e);
                    end
                end
            end
        end
    end

    task automatic push_frame(input logic [7:0] lo, input logic [7:0] hi);
        rx_q.push_back(lo);
        rx_q.push_back(hi);
        smp_q.push_back({hi, lo});
        tx_q.push_back(lo);
        tx_q.push_back(hi);
        exp_frames = exp_frames + 16'd1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_100MHz);
            if (rx_q.size() == 0 && smp_q.size() == 0 && tx_q.size() == 0 && !busy && !res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_100MHz);
        checks++;
        if ({rx_rd, tx_wr, smp_valid, res_ready, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 00000", {rx_rd, tx_wr, smp_valid, res_ready, busy});
        end
        checks++;
        if (smp_data !== 16'h0 || tx_data !== 8'h0 || frame_cnt !== 16'h0 || err_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_values: smp=%h tx=%h frames=%h errs=%h required all 0", smp_data, tx_data, frame_cnt, err_cnt);
        end
        @(posedge clk_100MHz); #1 reset = 1'b0;
        @(negedge clk_100MHz);
        checks++;
        if (busy !== 1'b0 || rx_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b rx_rd=%b required 0 0", busy, rx_rd);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int t0, t1, n;
        @(posedge clk_100MHz); #1 push_frame(8'h34, 8'h12);
        t0 = -1; t1 = -1; n = 0;
        for (int i = 0; i < 40 && t1 < 0; i++) begin
            @(negedge clk_100MHz);
            if (rx_rd && t0 < 0) t0 = cyc;
            if (tx_wr) begin n++; if (n == 2) t1 = cyc; end
        end
        checks++;
        if (t0 < 0 || t1 < 0 || (t1 - t0) !== 5) begin
            errors++;
            $display("FAIL latency: got %0d cycles required 5", t1 - t0);
        end
        wait_idle(50, ok);
        checks++;
        if (!ok || frame_cnt !== exp_frames) begin
            errors++;
            $display("FAIL basic_frame_cnt: got %h (idle=%b) required %h", frame_cnt, ok, exp_frames);
        end
    endtask

    task automatic test_tx_stall();
        bit ok, seen;
        int bad;
        @(posedge clk_100MHz); #1 tx_full = 1'b1; push_frame(8'hC3, 8'h5A);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_100MHz);
            if (res_ready) seen = 1'b1;
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_100MHz);
            if (tx_wr !== 1'b0 || busy !== 1'b1 || tx_data !== 8'hC3) bad++;
        end
        checks++;
        if (!seen || bad != 0) begin
            errors++;
            $display("FAIL tx_stall: reached=%b bad_cycles=%0d required 1 and 0", seen, bad);
        end
        @(posedge clk_100MHz); #1 tx_full = 1'b0;
        wait_idle(50, ok);
        checks++;
        if (!ok || frame_cnt !== exp_frames) begin
            errors++;
            $display("FAIL stall_frame_cnt: got %h (idle=%b) required %h", frame_cnt, ok, exp_frames);
        end
    endtask

    task automatic test_smp_stall();
        bit ok, seen;
        int bad;
        @(posedge clk_100MHz); #1 smp_ready = 1'b0; push_frame(8'hEF, 8'hBE);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_100MHz);
            if (smp_valid) seen = 1'b1;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_100MHz);
            if (smp_valid !== 1'b1 || smp_data !== 16'hBEEF) bad++;
        end
        checks++;
        if (!seen || bad != 0) begin
            errors++;
            $display("FAIL smp_hold: reached=%b bad_cycles=%0d required 1 and 0", seen, bad);
        end
        @(posedge clk_100MHz); #1 smp_ready = 1'b1;
        wait_idle(50, ok);
        checks++;
        if (!ok || frame_cnt !== exp_frames) begin
            errors++;
            $display("FAIL smp_stall_frame_cnt: got %h (idle=%b) required %h", frame_cnt, ok, exp_frames);
        end
    endtask

    task automatic test_timeout();
        bit ok, seen, sv;
        int n;
        @(posedge clk_100MHz); #1 rx_q.push_back(8'hAA);
        exp_err = exp_err + 8'd1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_100MHz);
            if (rx_rd) seen = 1'b1;
        end
        n = 0; sv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_100MHz);
            if (smp_valid) sv = 1'b1;
            if (busy) n++; else break;
        end
        checks++;
        if (!seen || n != TIMEOUT_CYC || sv) begin
            errors++;
            $display("FAIL timeout_len: busy for %0d cycles (smp_valid=%b) required %0d (0)", n, sv, TIMEOUT_CYC);
        end
        checks++;
        if (err_cnt !== exp_err) begin
            errors++;
            $display("FAIL timeout_err_cnt: got %h required %h", err_cnt, exp_err);
        end
        @(posedge clk_100MHz); #1 push_frame(8'h01, 8'h02);
        wait_idle(50, ok);
        checks++;
        if (!ok || frame_cnt !== exp_frames || err_cnt !== exp_err) begin
            errors++;
            $display("FAIL after_timeout: frames=%h errs=%h required %h %h", frame_cnt, err_cnt, exp_frames, exp_err);
        end
    endtask

    task automatic test_timeout_edge();
        bit ok, seen;
        int n;
        @(posedge clk_100MHz); #1
        rx_q.push_back(8'h55);
        smp_q.push_back(16'h6655);
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h66);
        exp_frames = exp_frames + 16'd1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_100MHz);
            if (rx_rd) seen = 1'b1;
        end
        n = 0;
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
            @(negedge clk_100MHz);
            if (busy) n++;
        end
        // The high byte lands exactly in the last timeout cycle.
        rx_q.push_back(8'h66);
        wait_idle(50, ok);
        checks++;
        if (!seen || n != TIMEOUT_CYC - 1 || !ok || err_cnt !== exp_err || frame_cnt !== exp_frames) begin
            errors++;
            $display("FAIL timeout_edge: busy=%0d idle=%b errs=%h frames=%h required %0d 1 %h %h",
                     n, ok, err_cnt, frame_cnt, TIMEOUT_CYC - 1, exp_err, exp_frames);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        @(posedge clk_100MHz); #1
        for (int i = 0; i < 6; i++) push_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        wait_idle(200, ok);
        checks++;
        if (!ok || frame_cnt !== exp_frames) begin
            errors++;
            $display("FAIL back_to_back: frames=%h idle=%b required %h", frame_cnt, ok, exp_frames);
        end
    endtask

    task automatic test_err_saturate();
        bit ok;
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk_100MHz); #1 rx_q.push_back(8'($urandom_range(0, 255)));
            exp_err = (exp_err == 8'hFF) ? exp_err : exp_err + 8'd1;
            wait_idle(40, ok);
            if (!ok) bad++;
        end
        checks++;
        if (bad != 0 || err_cnt !== 8'hFF || exp_err !== 8'hFF) begin
            errors++;
            $display("FAIL err_saturate: got %h (stuck=%0d) required ff", err_cnt, bad);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int pushes;
        @(posedge clk_100MHz); #1 res_stall = 1'b1; push_frame(8'h77, 8'h99);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_100MHz);
            if (res_ready) seen = 1'b1;
        end
        @(posedge clk_100MHz); #1 reset = 1'b1;
        #1;
        checks++;
        if (!seen || {rx_rd, tx_wr, smp_valid, res_ready, busy} !== 5'b0 || tx_data !== 8'h0 ||
            smp_data !== 16'h0 || frame_cnt !== 16'h0 || err_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_mid: reached=%b strobes=%b tx=%h smp=%h frames=%h errs=%h required 1 00000 00 0000 0000 00",
                     seen, {rx_rd, tx_wr, smp_valid, res_ready, busy}, tx_data, smp_data, frame_cnt, err_cnt);
        end
        rx_q.delete(); smp_q.delete(); tx_q.delete();
        exp_frames = 16'h0; exp_err = 8'h0; res_stall = 1'b0;
        repeat (2) @(posedge clk_100MHz);
        #1 reset = 1'b0;
        pushes = 0;
        repeat (10) begin
            @(negedge clk_100MHz);
            if (tx_wr) pushes++;
        end
        checks++;
        if (pushes != 0) begin
            errors++;
            $display("FAIL reset_no_tx: got %0d pushes required 0", pushes);
        end
        @(posedge clk_100MHz); #1 push_frame(8'h10, 8'h20);
        wait_idle(50, ok);
        checks++;
        if (!ok || frame_cnt !== exp_frames) begin
            errors++;
            $display("FAIL reset_recover: frames=%h idle=%b required %h", frame_cnt, ok, exp_frames);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        @(negedge clk_100MHz);
        force dut.frame_cnt = 16'hFFFE;
        @(posedge clk_100MHz); #1 release dut.frame_cnt;
        exp_frames = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_100MHz); #1 push_frame(8'(i), 8'hF0);
            wait_idle(50, ok);
            checks++;
            if (!ok || frame_cnt !== exp_frames) begin
                errors++;
                $display("FAIL frame_wrap_%0d: got %h (idle=%b) required %h", i, frame_cnt, ok, exp_frames);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_tx_stall();
        test_smp_stall();
        test_timeout();
        test_timeout_edge();
        test_back_to_back();
        test_err_saturate();
        test_reset_mid();
        test_wrap();
        repeat (2) @(negedge clk_100MHz);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
